// File: rtl/lieat_exu_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 encodings, tracker op code, widths, FSM states and a negate helper.
package lieat_exu_muldiv_pkg;

  localparam int XLEN       = 32;
  localparam int RGIDX_SIZE = 5;

  localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
  localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
  localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
  localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
  localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
  localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
  localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

  // Code identifying this unit's retire to the decode-side dependency tracker.
  localparam logic [1:0] MULDIV_LONGI_OP = 2'b10;

  // Counter value of the 32nd (final) iteration.
  localparam logic [4:0] MULDIV_LAST_CNT = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_e;

  // Two's-complement negation when en is set, pass-through otherwise.
  function automatic logic [31:0] neg32(input logic [31:0] v, input logic en);
    return en ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/lieat_exu_muldiv_dp.sv
// Iteration datapath: operand magnitudes and sign tracking, a shared 64-bit
// accumulator (shift-add multiply / restoring divide), final negation and the
// registered result word. Special cases are resolved here on load.
module lieat_exu_muldiv_dp
  import lieat_exu_muldiv_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            load_i,
  input  logic            step_i,
  input  logic            last_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            special_o,
  output logic [XLEN-1:0] wdat_o
);

  logic [63:0] acc_q, acc_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [2:0]  op_q, op_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] wdat_q, wdat_d;

  logic        a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
  logic [31:0] a_mag_s, b_mag_s;
  logic        div_zero_s, ovf_s;
  logic [31:0] special_res_s;
  logic [32:0] sum_s;
  logic [32:0] shifted_s;
  logic        ge_s;
  logic [31:0] diff_s;
  logic [63:0] acc_nxt_s;
  logic [63:0] prod_s;
  logic [31:0] final_res_s;

  // Load-time decode: signedness, magnitudes and special-case detection.
  always_comb begin
    a_sgn_s    = (op_i == MULDIV_OP_MULH) || (op_i == MULDIV_OP_MULHSU) ||
                 (op_i == MULDIV_OP_DIV)  || (op_i == MULDIV_OP_REM);
    b_sgn_s    = (op_i == MULDIV_OP_MULH) || (op_i == MULDIV_OP_DIV) ||
                 (op_i == MULDIV_OP_REM);
    a_neg_s    = a_sgn_s & rs1_i[31];
    b_neg_s    = b_sgn_s & rs2_i[31];
    a_mag_s    = neg32(rs1_i, a_neg_s);
    b_mag_s    = neg32(rs2_i, b_neg_s);
    div_zero_s = op_i[2] & (rs2_i == 32'd0);
    ovf_s      = ((op_i == MULDIV_OP_DIV) || (op_i == MULDIV_OP_REM)) &&
                 (rs1_i == 32'h8000_0000) && (rs2_i == 32'hFFFF_FFFF);
    special_o  = div_zero_s | ovf_s;
    if (div_zero_s) begin
      special_res_s = op_i[1] ? rs1_i : 32'hFFFF_FFFF;
    end else begin
      special_res_s = op_i[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // One iteration step for either operation, then the signed final result.
  always_comb begin
    // multiply: low word holds the unconsumed multiplier bits
    sum_s     = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, dvsr_q} : 33'd0);
    // divide: upper word is the partial remainder, lower word the dividend/quotient
    shifted_s = {acc_q[63:32], acc_q[31]};
    ge_s      = (shifted_s >= {1'b0, dvsr_q});
    diff_s    = shifted_s[31:0] - dvsr_q;
    if (op_q[2]) begin
      acc_nxt_s = {(ge_s ? diff_s : shifted_s[31:0]), acc_q[30:0], ge_s};
    end else begin
      acc_nxt_s = {sum_s, acc_q[31:1]};
    end
    prod_s = qneg_q ? (64'd0 - acc_nxt_s) : acc_nxt_s;
    case (op_q)
      MULDIV_OP_MUL:                   final_res_s = prod_s[31:0];
      MULDIV_OP_MULH, MULDIV_OP_MULHSU,
      MULDIV_OP_MULHU:                 final_res_s = prod_s[63:32];
      MULDIV_OP_DIV, MULDIV_OP_DIVU:   final_res_s = neg32(acc_nxt_s[31:0], qneg_q);
      MULDIV_OP_REM, MULDIV_OP_REMU:   final_res_s = neg32(acc_nxt_s[63:32], rneg_q);
      default:                         final_res_s = 32'd0;
    endcase
  end

  // Next-state selection for datapath registers: load, iterate or hold.
  always_comb begin
    acc_d  = acc_q;
    dvsr_d = dvsr_q;
    op_d   = op_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    wdat_d = wdat_q;
    if (load_i) begin
      // multiply keeps the multiplier low and adds the multiplicand;
      // divide keeps the dividend low and subtracts the divisor
      acc_d  = {32'd0, (op_i[2] ? a_mag_s : b_mag_s)};
      dvsr_d = op_i[2] ? b_mag_s : a_mag_s;
      op_d   = op_i;
      qneg_d = a_neg_s ^ b_neg_s;
      rneg_d = a_neg_s;
      if (special_o) begin
        wdat_d = special_res_s;
      end else begin
        wdat_d = wdat_q;
      end
    end else if (step_i) begin
      acc_d = acc_nxt_s;
      if (last_i) begin
        wdat_d = final_res_s;
      end else begin
        wdat_d = wdat_q;
      end
    end else begin
      acc_d = acc_q;
    end
  end

  // Datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q  <= 64'd0;
      dvsr_q <= 32'd0;
      op_q   <= 3'd0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      wdat_q <= 32'd0;
    end else begin
      acc_q  <= acc_d;
      dvsr_q <= dvsr_d;
      op_q   <= op_d;
      qneg_q <= qneg_d;
      rneg_q <= rneg_d;
      wdat_q <= wdat_d;
    end
  end

  assign wdat_o = wdat_q;

endmodule

// File: rtl/lieat_exu_muldiv.sv
// Iterative RV32M multiply/divide unit: IDLE/CALC/DONE control, iteration
// counter, dispatch and writeback handshakes, flush, and the tracker retire pulse.
module lieat_exu_muldiv
  import lieat_exu_muldiv_pkg::*;
#(
  parameter logic [1:0] LONGI_OP = MULDIV_LONGI_OP
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  muldiv_i_valid,
  output logic                  muldiv_i_ready,
  input  logic [2:0]            muldiv_i_op,
  input  logic [XLEN-1:0]       muldiv_i_rs1,
  input  logic [XLEN-1:0]       muldiv_i_rs2,
  input  logic [RGIDX_SIZE-1:0] muldiv_i_rd,
  output logic                  muldiv_o_valid,
  input  logic                  muldiv_o_ready,
  output logic [XLEN-1:0]       muldiv_o_wdat,
  output logic [RGIDX_SIZE-1:0] muldiv_o_rd,
  input  logic                  flush_req,
  output logic                  longi_wbck,
  output logic [1:0]            longi_wbck_op
);

  muldiv_state_e         state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [RGIDX_SIZE-1:0] rd_q, rd_d;
  logic                  in_hs_s;
  logic                  special_s;
  logic                  last_s;
  logic                  wbck_s;

  assign muldiv_i_ready = rstn & (state_q == ST_IDLE) & ~flush_req;
  assign in_hs_s        = muldiv_i_valid & muldiv_i_ready;
  assign last_s         = (cnt_q == MULDIV_LAST_CNT);

  // Next state and retire pulse; retire happens on result handshake or flush.
  always_comb begin
    state_d = state_q;
    wbck_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_hs_s) begin
          state_d = special_s ? ST_DONE : ST_CALC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (flush_req) begin
          state_d = ST_IDLE;
          wbck_s  = 1'b1;
        end else if (last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CALC;
        end
      end
      ST_DONE: begin
        // a flush coinciding with the handshake still retires only once
        if (muldiv_o_ready || flush_req) begin
          state_d = ST_IDLE;
          wbck_s  = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Iteration counter and destination index next values.
  always_comb begin
    if ((state_q == ST_CALC) && !last_s && !flush_req) begin
      cnt_d = cnt_q + 5'd1;
    end else begin
      cnt_d = 5'd0;
    end
    if (in_hs_s) begin
      rd_d = muldiv_i_rd;
    end else begin
      rd_d = rd_q;
    end
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 5'd0;
      rd_q    <= {RGIDX_SIZE{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  lieat_exu_muldiv_dp u_dp (
    .clk       (clk),
    .rstn      (rstn),
    .load_i    (in_hs_s),
    .step_i    ((state_q == ST_CALC) & ~flush_req),
    .last_i    (last_s),
    .op_i      (muldiv_i_op),
    .rs1_i     (muldiv_i_rs1),
    .rs2_i     (muldiv_i_rs2),
    .special_o (special_s),
    .wdat_o    (muldiv_o_wdat)
  );

  assign muldiv_o_valid = (state_q == ST_DONE);
  assign muldiv_o_rd    = rd_q;
  assign longi_wbck     = rstn & wbck_s;
  assign longi_wbck_op  = LONGI_OP;

endmodule
